// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions: sequencer state encodings and RV32I major opcodes.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StFetch     = 3'd1,
        StDecode    = 3'd2,
        StExecute   = 3'd3,
        StMem       = 3'd4,
        StWriteback = 3'd5,
        StTrap      = 3'd6
    } state_e;

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;

    // True for every major opcode the datapath implements.
    function automatic logic is_legal_opcode(input logic [6:0] opc);
        logic legal;
        case (opc)
            OpcOp, OpcOpImm, OpcLoad, OpcStore, OpcBranch,
            OpcAuipc, OpcLui, OpcJal, OpcJalr: legal = 1'b1;
            default:                           legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Clearable saturating wait counter; flags a timeout once MEM_TIMEOUT wait cycles have elapsed.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic timeout_o
);

    localparam int unsigned CntW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] Limit = CntW'(MEM_TIMEOUT);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise count up and hold at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != Limit)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A zero limit disables the timeout entirely.
    assign timeout_o = (MEM_TIMEOUT != 0) && (cnt_q == Limit);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle RV32I control FSM: fetch, decode, execute, memory, writeback, with halt and trap.
module cpu_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic                 dec_reg_write,
    input  logic                 dec_mem_read,
    input  logic                 dec_mem_write,
    input  logic                 dec_branch,
    input  logic                 dec_jump,
    input  logic                 branch_taken,
    input  logic                 mem_ready,
    input  logic                 halt_req,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 mem_addr_sel,
    output logic                 ir_en,
    output logic                 alu_res_en,
    output logic                 rf_we,
    output logic                 pc_en,
    output logic                 pc_sel,
    output logic                 trap,
    output logic [2:0]           state,
    output logic [INSTRET_W-1:0] instret
);

    state_e               state_q, state_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;
    logic                 mem_wait;
    logic                 timer_clr;
    logic                 timeout;

    // The timer only advances while a request is outstanding. Every entry to FETCH or MEM
    // comes from a non-waiting cycle, so clearing whenever not waiting starts each access at 0.
    assign mem_wait  = ((state_q == StFetch) || (state_q == StMem)) && !mem_ready;
    assign timer_clr = !mem_wait;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk_i    (clk),
        .rst_i    (rst),
        .clr_i    (timer_clr),
        .inc_i    (mem_wait),
        .timeout_o(timeout)
    );

    // Next-state, retire count and per-state strobes.
    always_comb begin
        state_d      = state_q;
        instret_d    = instret_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_en        = 1'b0;
        alu_res_en   = 1'b0;
        rf_we        = 1'b0;
        pc_en        = 1'b0;
        pc_sel       = 1'b0;
        trap         = 1'b0;
        case (state_q)
            StIdle: begin
                if (!halt_req) state_d = StFetch;
            end
            StFetch: begin
                mem_req = 1'b1;
                // A response arriving on the limit cycle still completes the fetch.
                if (mem_ready) begin
                    ir_en   = 1'b1;
                    state_d = StDecode;
                end else if (timeout) begin
                    state_d = StTrap;
                end
            end
            StDecode: begin
                state_d = is_legal_opcode(opcode) ? StExecute : StTrap;
            end
            StExecute: begin
                alu_res_en = 1'b1;
                state_d    = (dec_mem_read || dec_mem_write) ? StMem : StWriteback;
            end
            StMem: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = dec_mem_write;
                if (mem_ready) begin
                    state_d = StWriteback;
                end else if (timeout) begin
                    state_d = StTrap;
                end
            end
            StWriteback: begin
                rf_we     = dec_reg_write;
                pc_en     = 1'b1;
                pc_sel    = dec_jump || (dec_branch && branch_taken);
                instret_d = instret_q + 1'b1;
                state_d   = halt_req ? StIdle : StFetch;
            end
            StTrap: begin
                trap = 1'b1;
            end
            default: begin
                // Unused encoding: treat as a fault.
                state_d = StTrap;
            end
        endcase
    end

    // State and retire-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    assign state   = state_q;
    assign instret = instret_q;

endmodule
